scancode_sequencer: RTL
=======================

SCANCODE_SEQUENCER -- requirements
Module: scancode_sequencer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, meaning character-event FIFO entries (power of two, 2..16).
REQ-002 Parameter REPEAT_FILTER, default 1, meaning 1 suppresses typematic repeats of the held key, 0 passes them.
REQ-003 vga_clk  in  1  single clock; all logic is on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 rx_data  in  8  byte from the PS/2 receiver.
REQ-006 rx_valid  in  1  one-cycle strobe qualifying rx_data.
REQ-007 scancode_out  out  8  scancode driven to the decoder.
REQ-008 flag_out  out  1  decoder trigger pulse.
REQ-009 dec_char_enable  in  1  decoder "character recognised" result.
REQ-010 dec_start_address  in  6  decoder glyph start address.
REQ-011 char_addr  out  6  FIFO head glyph address.
REQ-012 char_valid  out  1  FIFO not empty.
REQ-013 char_ready  in  1  consumer accepts head when char_valid=1.
REQ-014 key_held  out  1  a decoded make code is currently held.
REQ-015 overflow  out  1  sticky; a recognised character was lost to a full FIFO.
REQ-016 rx_dropped  out  1  sticky; a byte arrived while the sequencer was busy.

Function
REQ-017 States: IDLE, BRK (F0 seen), EXT (E0 seen), EXTBRK (E0 F0 seen), DECODE, WAIT, CAPTURE.
REQ-018 In IDLE, rx_valid with F0 -> BRK; E0 -> EXT; any other byte -> make-code handling (REQ-020).
REQ-019 BRK, rx_valid with byte B: if key_held and B equals held code, clear key_held; -> IDLE; no decode.
REQ-020 Make code B in IDLE: if REPEAT_FILTER=1, key_held=1 and B equals held code -> discard, stay IDLE; otherwise load scancode_out=B, held code=B, key_held=1, -> DECODE.
REQ-021 EXT, rx_valid: F0 -> EXTBRK; other byte -> IDLE, discarded (extended keys not decoded, held state unchanged).
REQ-022 EXTBRK, rx_valid: any byte -> IDLE, discarded.
REQ-023 DECODE: flag_out=1 for exactly this one cycle; -> WAIT.
REQ-024 WAIT: flag_out=0; -> CAPTURE (one settling cycle for decoder outputs).
REQ-025 CAPTURE: sample dec_char_enable/dec_start_address; if enable=1 push address to FIFO (or set overflow if full); -> IDLE.
REQ-026 Latency: make code strobed in cycle N -> flag_out high in N+1, capture in N+3, char_valid high in N+4 (FIFO previously empty).
REQ-027 rx_valid during DECODE, WAIT or CAPTURE: byte discarded, rx_dropped set, state sequence unaffected.
REQ-028 flag_out is 0 in every state except DECODE; scancode_out holds its value until the next accepted make code.
REQ-029 FIFO: first-word-fall-through; char_addr = oldest entry while char_valid=1; pop when char_valid and char_ready in the same cycle.
REQ-030 Simultaneous push and pop when full: both occur, no overflow; when empty: push only (pop ignored, char_valid was 0).
REQ-031 Read/write pointers wrap modulo FIFO_DEPTH; occupancy counter width clog2(FIFO_DEPTH)+1, never exceeds FIFO_DEPTH.
REQ-032 dec_char_enable=0 in CAPTURE: nothing pushed, no flag set; key_held remains set.
REQ-033 overflow and rx_dropped clear only on reset.

Reset
REQ-034 reset=1 at a rising edge: state=IDLE, scancode_out=8'h00, flag_out=0, key_held=0, held code=8'h00, FIFO empty (char_valid=0, char_addr=0), overflow=0, rx_dropped=0.
REQ-035 Reset mid-sequence (any state, including DECODE with flag_out=1) aborts the sequence; flag_out=0 the next cycle; no push occurs.
REQ-036 Inputs during reset are ignored; first byte is accepted the cycle after reset deasserts.

Verification
REQ-037 Byte 2B (decoder returns enable=1, addr 000000) at cycle N -> flag_out=1 at N+1, char_valid=1 with char_addr=000000 at N+4, key_held=1.
REQ-038 2B, 2B, F0 2B, 2B with REPEAT_FILTER=1 -> exactly two pushes, key_held=0 after F0 2B, then 1.
REQ-039 E0 15 and E0 F0 15 -> no flag_out pulse, FIFO unchanged, key_held unchanged.
REQ-040 Five recognised keys (15,33,22,2B,15, with intervening breaks) with char_ready=0, depth 4 -> four entries in order 010000,100000,110000,000000; overflow=1.
REQ-041 rx_valid in cycle N+2 after a make code at N -> byte discarded, rx_dropped=1, capture still at N+3.
REQ-042 Unrecognised make 1C (enable=0) -> flag_out pulse, no push, key_held=1; reset asserted during WAIT -> all outputs at REQ-034 values next cycle.

Source files
------------

// File: rtl/scancode_sequencer.sv
`timescale 1ns/1ps
// scancode_sequencer
// Turns the PS/2 receiver byte stream into single decode requests for the
// glyph decoder and queues recognised glyph addresses for the display side.
// Break (F0) and extended (E0) prefixes are tracked so that only plain make
// codes reach the decoder; typematic repeats of the held key can be filtered.
//
// Character output handshake: char_valid is high whenever the FIFO holds at
// least one entry and char_addr then shows the oldest entry. An entry is
// consumed on a rising edge where char_valid and char_ready are both high.
// char_ready while char_valid is low has no effect. char_valid does not
// depend combinationally on char_ready.
//
// FIFO_DEPTH must be a power of two in the range 2..16.
module scancode_sequencer #(
  parameter int FIFO_DEPTH    = 4,
  parameter int REPEAT_FILTER = 1
) (
  input  logic       vga_clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] scancode_out,
  output logic       flag_out,
  input  logic       dec_char_enable,
  input  logic [5:0] dec_start_address,
  output logic [5:0] char_addr,
  output logic       char_valid,
  input  logic       char_ready,
  output logic       key_held,
  output logic       overflow,
  output logic       rx_dropped,
  output logic [2:0] state_dbg
);

  localparam logic [7:0] BREAK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE   = 8'hE0;

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_BRK     = 3'd1,
    S_EXT     = 3'd2,
    S_EXTBRK  = 3'd3,
    S_DECODE  = 3'd4,
    S_WAIT    = 3'd5,
    S_CAPTURE = 3'd6
  } state_t;

  state_t state;
  state_t state_nxt;

  // Control strobes produced by the next-state logic.
  logic load_make;    // accept rx_data as a new make code
  logic release_key;  // break code matched the held key
  logic drop_byte;    // byte arrived while a decode was in flight
  logic capture;      // decoder outputs are sampled this cycle
  logic is_repeat;    // make code equals the held key and repeats are filtered

  logic [7:0] held_code;

  // FIFO storage and bookkeeping.
  logic [5:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             fifo_full;
  logic             push_req;
  logic             push;
  logic             pop;
  logic             lost;

  assign is_repeat = (REPEAT_FILTER != 0) && key_held && (rx_data == held_code);

  // State register.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and control strobes; prefixes never reach the decoder.
  always_comb begin
    state_nxt   = state;
    load_make   = 1'b0;
    release_key = 1'b0;
    drop_byte   = 1'b0;
    capture     = 1'b0;
    case (state)
      S_IDLE: begin
        if (rx_valid) begin
          if (rx_data == BREAK_CODE) begin
            state_nxt = S_BRK;
          end else if (rx_data == EXT_CODE) begin
            state_nxt = S_EXT;
          end else if (!is_repeat) begin
            load_make = 1'b1;
            state_nxt = S_DECODE;
          end
        end
      end
      S_BRK: begin
        if (rx_valid) begin
          release_key = key_held && (rx_data == held_code);
          state_nxt   = S_IDLE;
        end
      end
      S_EXT: begin
        if (rx_valid) begin
          state_nxt = (rx_data == BREAK_CODE) ? S_EXTBRK : S_IDLE;
        end
      end
      S_EXTBRK: begin
        if (rx_valid) begin
          state_nxt = S_IDLE;
        end
      end
      S_DECODE: begin
        drop_byte = rx_valid;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        drop_byte = rx_valid;
        state_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        drop_byte = rx_valid;
        capture   = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // The decoder trigger is exactly the one cycle spent in DECODE.
  assign flag_out  = (state == S_DECODE);
  assign state_dbg = state;

  // Scancode presented to the decoder and the currently held key.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      scancode_out <= 8'h00;
      held_code    <= 8'h00;
      key_held     <= 1'b0;
    end else if (load_make) begin
      scancode_out <= rx_data;
      held_code    <= rx_data;
      key_held     <= 1'b1;
    end else if (release_key) begin
      key_held <= 1'b0;
    end
  end

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign fifo_full  = (count == DEPTH_C);
  assign char_valid = (count != '0);
  assign pop        = char_valid && char_ready;
  assign push_req   = capture && dec_char_enable;
  assign push       = push_req && (!fifo_full || pop);
  assign lost       = push_req && fifo_full && !pop;
  assign char_addr  = char_valid ? mem[rd_ptr] : 6'd0;

  // FIFO storage; contents need no reset because char_valid gates them.
  always_ff @(posedge vga_clk) begin
    if (!reset && push) begin
      mem[wr_ptr] <= dec_start_address;
    end
  end

  // FIFO pointers and occupancy; pointers wrap because depth is a power of two.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      overflow   <= 1'b0;
      rx_dropped <= 1'b0;
    end else begin
      overflow   <= overflow | lost;
      rx_dropped <= rx_dropped | drop_byte;
    end
  end

endmodule
